// File: rtl/eth_tx_serializer.sv
// RMII-style dibit transmitter: 802.3 preamble/SFD, LSB-first payload and interframe gap.
// Defining CRC_APPEND_EN adds the CRC-32 engine and a 16-dibit FCS after the payload.
module eth_tx_serializer #(
  parameter int IFG_DIBITS = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  input  logic       axiilast,
  output logic       axiiready,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       busy,
  output logic       underflow
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    PAYLOAD  = 3'd2,
    FCS      = 3'd3,
    GAP      = 3'd4
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'd31;
  localparam logic [7:0] FCS_LAST = 8'd15;
  localparam logic [7:0] GAP_LAST = 8'(IFG_DIBITS - 1);

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] byte_r, byte_s;
  logic       last_r, last_s;
  logic       axiov_r, axiov_s;
  logic [1:0] axiod_r, axiod_s;
  logic       ready_r, ready_s;
  logic       underflow_r, underflow_s;

`ifdef CRC_APPEND_EN
  logic [31:0] crc_r, crc_s, crc_upd_s;

  // Reflected CRC-32 advanced by one dibit, bit [0] of the dibit first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ d[i]) begin
        c = {1'b0, c[31:1]} ^ 32'hEDB88320;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

  assign crc_upd_s = crc32_dibit(crc_r, axiod_r);
`endif

  // Next-state and next-output decode; registered outputs describe the cycle being entered.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    byte_s      = byte_r;
    last_s      = last_r;
    axiov_s     = 1'b0;
    axiod_s     = 2'b00;
    ready_s     = 1'b0;
    underflow_s = 1'b0;
`ifdef CRC_APPEND_EN
    crc_s       = crc_r;
`endif
    case (state_r)
      IDLE: begin
        if (axiiv) begin
          state_s = PREAMBLE;
          cnt_s   = 8'd0;
          axiov_s = 1'b1;
          axiod_s = 2'b01;
`ifdef CRC_APPEND_EN
          crc_s   = 32'hFFFFFFFF;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      PREAMBLE: begin
        if (cnt_r != PRE_LAST) begin
          cnt_s   = cnt_r + 8'd1;
          axiov_s = 1'b1;
          axiod_s = (cnt_s == PRE_LAST) ? 2'b11 : 2'b01;
          ready_s = (cnt_s == PRE_LAST);
        end else if (axiiv) begin
          state_s = PAYLOAD;
          cnt_s   = 8'd0;
          byte_s  = axiid;
          last_s  = axiilast;
          axiov_s = 1'b1;
          axiod_s = axiid[1:0];
        end else begin
          state_s     = GAP;
          cnt_s       = 8'd0;
          underflow_s = 1'b1;
        end
      end
      PAYLOAD: begin
`ifdef CRC_APPEND_EN
        crc_s = crc_upd_s;
`endif
        if (cnt_r != 8'd3) begin
          cnt_s   = cnt_r + 8'd1;
          byte_s  = {2'b00, byte_r[7:2]};
          axiov_s = 1'b1;
          axiod_s = byte_r[3:2];
          ready_s = (cnt_s == 8'd3) && !last_r;
        end else if (last_r) begin
          cnt_s = 8'd0;
`ifdef CRC_APPEND_EN
          state_s = FCS;
          axiov_s = 1'b1;
          axiod_s = ~crc_upd_s[1:0];
          crc_s   = {2'b00, crc_upd_s[31:2]};
`else
          state_s = GAP;
`endif
        end else if (axiiv) begin
          cnt_s   = 8'd0;
          byte_s  = axiid;
          last_s  = axiilast;
          axiov_s = 1'b1;
          axiod_s = axiid[1:0];
        end else begin
          state_s     = GAP;
          cnt_s       = 8'd0;
          underflow_s = 1'b1;
        end
      end
`ifdef CRC_APPEND_EN
      FCS: begin
        if (cnt_r != FCS_LAST) begin
          cnt_s   = cnt_r + 8'd1;
          axiov_s = 1'b1;
          axiod_s = ~crc_r[1:0];
          crc_s   = {2'b00, crc_r[31:2]};
        end else begin
          state_s = GAP;
          cnt_s   = 8'd0;
        end
      end
`endif
      GAP: begin
        // The final gap cycle already applies the IDLE rules so back-to-back frames see exactly IFG_DIBITS idle cycles.
        if (cnt_r != GAP_LAST) begin
          cnt_s = cnt_r + 8'd1;
        end else if (axiiv) begin
          state_s = PREAMBLE;
          cnt_s   = 8'd0;
          axiov_s = 1'b1;
          axiod_s = 2'b01;
`ifdef CRC_APPEND_EN
          crc_s   = 32'hFFFFFFFF;
`endif
        end else begin
          state_s = IDLE;
          cnt_s   = 8'd0;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      byte_r      <= 8'd0;
      last_r      <= 1'b0;
      axiov_r     <= 1'b0;
      axiod_r     <= 2'b00;
      ready_r     <= 1'b0;
      underflow_r <= 1'b0;
`ifdef CRC_APPEND_EN
      crc_r       <= 32'hFFFFFFFF;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      byte_r      <= byte_s;
      last_r      <= last_s;
      axiov_r     <= axiov_s;
      axiod_r     <= axiod_s;
      ready_r     <= ready_s;
      underflow_r <= underflow_s;
`ifdef CRC_APPEND_EN
      crc_r       <= crc_s;
`endif
    end
  end

  assign axiov     = axiov_r;
  assign axiod     = axiod_r;
  assign axiiready = ready_r;
  assign underflow = underflow_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: doc/eth_tx_serializer.md
ETH_TX_SERIALIZER -- requirements
Module: eth_tx_serializer

Interface
REQ-001 SHALL have parameter IFG_DIBITS, default 48, interframe-gap length in clock cycles (dibits), legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz RMII reference; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port axiiv  input  1  payload byte valid.
REQ-005 SHALL have port axiid  input  8  payload byte.
REQ-006 SHALL have port axiilast  input  1  marks final payload byte of frame; qualified by axiiv.
REQ-007 SHALL have port axiiready  output  1  byte accepted on clk edge where axiiv and axiiready are both high.
REQ-008 SHALL have port axiov  output  1  transmit enable, TX_EN equivalent.
REQ-009 SHALL have port axiod  output  2  transmit dibit, TXD equivalent.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port underflow  output  1  one-cycle pulse on payload starvation abort.

Function
REQ-012 SHALL implement states IDLE, PREAMBLE, PAYLOAD, FCS, GAP.
REQ-013 IDLE: axiov=0, axiod=00, axiiready=0; axiiv=1 -> PREAMBLE next cycle; byte not consumed.
REQ-014 PREAMBLE: exactly 32 cycles, axiov=1; dibits 1..31 = 01, dibit 32 = 11 (0x55 x7, 0xD5 SFD).
REQ-015 axiiready SHALL be high only on the last cycle of PREAMBLE and on the 4th dibit cycle of each non-last PAYLOAD byte.
REQ-016 PAYLOAD: each byte sent over 4 cycles, LSB first: axiod = [1:0], [3:2], [5:4], [7:6].
REQ-017 Back-to-back bytes SHALL be gapless; axiov stays high across byte boundaries.
REQ-018 Byte with axiilast=1: after its 4th dibit -> FCS (CRC_APPEND_EN) or GAP (otherwise); axiiready stays low until GAP ends.
REQ-019 Underflow: axiiready high and axiiv low -> axiov=0 next cycle, underflow pulses 1 cycle, -> GAP; no FCS.
REQ-020 CRC: IEEE 802.3 CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF, updated per dibit over payload only (preamble/SFD excluded).
REQ-021 FCS: 16 cycles, inverted CRC register sent LSB first (bits [1:0] first, [31:30] last).
REQ-022 GAP: IFG_DIBITS cycles, axiov=0, axiod=00, then IDLE; axiiv ignored during GAP.
REQ-023 axiod SHALL be 00 whenever axiov=0.
REQ-024 Outputs axiov, axiod, axiiready SHALL be registered; axiov rises the cycle after axiiv is sampled high in IDLE.
REQ-025 One-byte frame (first byte has axiilast=1) SHALL be legal; no minimum-length padding.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, axiov=0, axiod=00, axiiready=0, busy=0, underflow=0, CRC=0xFFFFFFFF.
REQ-027 Reset mid-frame SHALL truncate the frame without FCS; first edge after release evaluates IDLE rules.

Configuration
REQ-028 Macro CRC_APPEND_EN defined: FCS state and CRC engine present, 32-bit FCS appended per REQ-021.
REQ-029 Macro CRC_APPEND_EN undefined: no CRC logic; last payload dibit followed directly by GAP; upstream supplies FCS bytes.

Verification
REQ-030 Payload "123456789" (0x31..0x39), CRC_APPEND_EN -> 84 axiov cycles; FCS bytes 26 39 F4 CB (CRC 0xCBF43926), first FCS dibit 10.
REQ-031 Single byte 0xA5 with axiilast -> dibits 01,01,10,10 after SFD 11; axiov low 16 cycles later (CRC) or immediately (no CRC).
REQ-032 axiiv dropped before 3rd byte of 10-byte frame -> axiov low after 2nd byte's 4th dibit, underflow=1 one cycle, no FCS, GAP 48 cycles.
REQ-033 Two frames, axiiv held high throughout -> exactly IFG_DIBITS=48 cycles of axiov=0 between frames; second preamble intact.
REQ-034 rst_n asserted mid-PAYLOAD -> axiov 0 same cycle (async); next frame after release transmits full preamble and correct FCS.
REQ-035 Build without CRC_APPEND_EN, 9-byte frame -> 68 axiov cycles, last dibit = [7:6] of 0x39 (00).
